multicycle_ctrl: RTL and testbench

- Moore/Mealy control FSM that sequences the 16-bit multicycle datapath (PC, IR, MDR, register file, ALU and its output register) through fetch, decode, execute, memory and write-back phases.
- Drives all register write enables, mux selects and the ALU op code.
- Performs a req/ack handshake with the shared instruction/data memory.
- Sits beside the datapath; receives only opcode, ALU zero flag and memory ack.

---
 rtl/multicycle_ctrl_pkg.sv | 86 ++++++++
 rtl/multicycle_ctrl_if.sv | 40 ++++
 rtl/multicycle_ctrl_out_decode.sv | 69 ++++++
 rtl/multicycle_ctrl.sv | 82 ++++++++
 tb/tb_multicycle_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multicycle control FSM: states, opcodes, ALU codes.
// MULTICYCLE_CTRL_ILLEGAL_TRAP_EN sends undefined opcodes to HALT.
package ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC_ALU,
        WB_ALU,
        MEM_ADDR,
        MEM_RD,
        WB_MEM,
        MEM_WR,
        BRANCH,
        JUMP,
        HALT
    } state_t;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_NOT = 4'h4;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_BEQ = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_NOT   = 3'd4;
    localparam logic [2:0] ALU_PASSB = 3'd5;

    localparam logic [1:0] PC_ALU = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;

    localparam logic [1:0] SRCB_RF  = 2'd0;
    localparam logic [1:0] SRCB_ONE = 2'd1;
    localparam logic [1:0] SRCB_IMM = 2'd2;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_sel;
        logic       ir_we;
        logic       mdr_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       rf_we;
        logic       rf_wsel;
        logic       busy;
    } ctrl_t;

    function automatic logic op_legal(input logic [3:0] op);
        return (op <= OP_NOT) ||
               (op inside {OP_LD, OP_ST, OP_BEQ, OP_JMP, OP_HLT});
    endfunction

    function automatic state_t decode_next(input logic [3:0] op);
        state_t nxt;
        unique case (1'b1)
            (op <= OP_NOT):              nxt = EXEC_ALU;
            (op == OP_LD), (op == OP_ST): nxt = MEM_ADDR;
            (op == OP_BEQ):              nxt = BRANCH;
            (op == OP_JMP):              nxt = JUMP;
            (op == OP_HLT):              nxt = HALT;
            default: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                nxt = HALT;
`else
                nxt = FETCH;
`endif
            end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle FSM and its datapath/memory.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if #(
    parameter int OPW  = 4,
    parameter int AOPW = 3
);
    logic            start;
    logic [OPW-1:0]  opcode;
    logic            zero;
    logic            mem_ack;
    logic            mem_req;
    logic            mem_we;
    logic            adr_sel;
    logic            ir_we;
    logic            mdr_we;
    logic            pc_we;
    logic [1:0]      pc_src;
    logic [AOPW-1:0] alu_op;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic            rf_we;
    logic            rf_wsel;
    logic            busy;
    logic            err;

    modport master (
        input  start, opcode, zero, mem_ack,
        output mem_req, mem_we, adr_sel, ir_we, mdr_we,
        output pc_we, pc_src, alu_op, alu_src_a, alu_src_b,
        output rf_we, rf_wsel, busy, err
    );

    modport slave (
        output start, opcode, zero, mem_ack,
        input  mem_req, mem_we, adr_sel, ir_we, mdr_we,
        input  pc_we, pc_src, alu_op, alu_src_a, alu_src_b,
        input  rf_we, rf_wsel, busy, err
    );

endinterface

// File: rtl/multicycle_ctrl_out_decode.sv
// State-to-control-vector table; only the memory strobes look at mem_ack
// and the branch PC write looks at zero.
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] alu_fn,
    input  logic       zero,
    input  logic       mem_ack,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        ctrl.busy = (state != IDLE) && (state != HALT);
        unique case (state)
            FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = SRCB_ONE;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PC_ALU;
                ctrl.ir_we     = mem_ack;
                ctrl.pc_we     = mem_ack;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            EXEC_ALU: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RF;
                ctrl.alu_op    = alu_fn;
            end
            WB_ALU: ctrl.rf_we = 1'b1;
            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            MEM_RD: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_sel = 1'b1;
                ctrl.mdr_we  = mem_ack;
            end
            WB_MEM: begin
                ctrl.rf_we   = 1'b1;
                ctrl.rf_wsel = 1'b1;
            end
            MEM_WR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.adr_sel = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RF;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = PC_BR;
                ctrl.pc_we     = zero;
            end
            JUMP: begin
                ctrl.pc_we  = 1'b1;
                ctrl.pc_src = PC_JMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle datapath controller: next-state FSM plus output table.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to halt with err on bad opcodes.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OPW         = 4,
    parameter int AOPW        = 3,
    parameter int HALT_ON_RST = 1
) (
    input logic               clk,
    input logic               rst,
    multicycle_ctrl_if.master bus
);

    state_t     state;
    state_t     nxt;
    ctrl_t      ctrl;
    logic [3:0] op;

    assign op = bus.opcode[OPW-1 -: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:     if (bus.start || HALT_ON_RST == 0) nxt = FETCH;
            FETCH:    if (bus.mem_ack) nxt = DECODE;
            DECODE:   nxt = decode_next(op);
            EXEC_ALU: nxt = WB_ALU;
            WB_ALU:   nxt = FETCH;
            MEM_ADDR: nxt = (op == OP_LD) ? MEM_RD : MEM_WR;
            MEM_RD:   if (bus.mem_ack) nxt = WB_MEM;
            WB_MEM:   nxt = FETCH;
            MEM_WR:   if (bus.mem_ack) nxt = FETCH;
            BRANCH:   nxt = FETCH;
            JUMP:     nxt = FETCH;
            HALT:     nxt = HALT;
            default:  nxt = IDLE;
        endcase
    end

    ctrl_out_decode u_dec (
        .state   (state),
        .alu_fn  (op[2:0]),
        .zero    (bus.zero),
        .mem_ack (bus.mem_ack),
        .ctrl    (ctrl)
    );

    assign bus.mem_req   = ctrl.mem_req;
    assign bus.mem_we    = ctrl.mem_we;
    assign bus.adr_sel   = ctrl.adr_sel;
    assign bus.ir_we     = ctrl.ir_we;
    assign bus.mdr_we    = ctrl.mdr_we;
    assign bus.pc_we     = ctrl.pc_we;
    assign bus.pc_src    = ctrl.pc_src;
    assign bus.alu_op    = AOPW'(ctrl.alu_op);
    assign bus.alu_src_a = ctrl.alu_src_a;
    assign bus.alu_src_b = ctrl.alu_src_b;
    assign bus.rf_we     = ctrl.rf_we;
    assign bus.rf_wsel   = ctrl.rf_wsel;
    assign bus.busy      = ctrl.busy;

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    logic err_q;

    // Sticky until reset; HALT never leaves, so err only clears with rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                err_q <= 1'b0;
        else if (state == DECODE && !op_legal(op)) err_q <= 1'b1;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed table, randomized model, corner cases.
// Works with or without MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_sel;
        logic       ir_we;
        logic       mdr_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       rf_we;
        logic       rf_wsel;
        logic       busy;
        logic       err;
    } exp_t;

    typedef struct packed {
        logic       ack;
        logic       zero;
        logic [3:0] op;
        exp_t       e;
    } cyc_t;

    typedef struct {
        logic [3:0] op;
        logic       zero;
        int         wf, wm, lat, rf, mw, mdr, pcw, dreq, wsel;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    cyc_t q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t smp();
        exp_t s;
        s.mem_req   = bus.mem_req;
        s.mem_we    = bus.mem_we;
        s.adr_sel   = bus.adr_sel;
        s.ir_we     = bus.ir_we;
        s.mdr_we    = bus.mdr_we;
        s.pc_we     = bus.pc_we;
        s.pc_src    = bus.pc_src;
        s.alu_op    = bus.alu_op;
        s.alu_src_a = bus.alu_src_a;
        s.alu_src_b = bus.alu_src_b;
        s.rf_we     = bus.rf_we;
        s.rf_wsel   = bus.rf_wsel;
        s.busy      = bus.busy;
        s.err       = bus.err;
        return s;
    endfunction

    function automatic logic is_fetch();
        return bus.mem_req && !bus.adr_sel && bus.busy;
    endfunction

    function automatic logic legal(input logic [3:0] op);
        return op <= 4'h4 || op == 4'h8 || op == 4'h9 ||
               op == 4'hA || op == 4'hB || op == 4'hF;
    endfunction

    function automatic cyc_t blank(input logic [3:0] op);
        cyc_t c;
        c.ack    = 1'($urandom);
        c.zero   = 1'($urandom);
        c.op     = op;
        c.e      = '0;
        c.e.busy = 1'b1;
        return c;
    endfunction

    // Reference: the cycle-by-cycle control vector an instruction should
    // produce, built from the instruction-class rules.
    task automatic push_instr(input logic [3:0] op, input int wf,
                              input int wm);
        cyc_t c;
        for (int i = 0; i <= wf; i++) begin
            c = blank(op);
            c.ack = (i == wf);
            c.e.mem_req = 1'b1;
            c.e.alu_src_b = 2'd1;
            c.e.ir_we = c.ack;
            c.e.pc_we = c.ack;
            q.push_back(c);
        end
        c = blank(op);
        c.e.alu_src_b = 2'd2;
        q.push_back(c);
        if (op <= 4'h4) begin
            c = blank(op);
            c.e.alu_src_a = 1'b1;
            c.e.alu_op = op[2:0];
            q.push_back(c);
            c = blank(op);
            c.e.rf_we = 1'b1;
            q.push_back(c);
        end else if (op == 4'h8 || op == 4'h9) begin
            c = blank(op);
            c.e.alu_src_a = 1'b1;
            c.e.alu_src_b = 2'd2;
            q.push_back(c);
            for (int i = 0; i <= wm; i++) begin
                c = blank(op);
                c.ack = (i == wm);
                c.e.mem_req = 1'b1;
                c.e.adr_sel = 1'b1;
                c.e.mem_we = (op == 4'h9);
                c.e.mdr_we = (op == 4'h8) && c.ack;
                q.push_back(c);
            end
            if (op == 4'h8) begin
                c = blank(op);
                c.e.rf_we = 1'b1;
                c.e.rf_wsel = 1'b1;
                q.push_back(c);
            end
        end else if (op == 4'hA) begin
            c = blank(op);
            c.e.alu_src_a = 1'b1;
            c.e.alu_op = 3'd1;
            c.e.pc_src = 2'd1;
            c.e.pc_we = c.zero;
            q.push_back(c);
        end else if (op == 4'hB) begin
            c = blank(op);
            c.e.pc_we = 1'b1;
            c.e.pc_src = 2'd2;
            q.push_back(c);
        end
    endtask

    // Reactive memory: acks after wf/wm wait cycles, random acks when idle.
    task automatic run_vec(input vec_t v, input int idx);
        int cyc, rf, mw, mdr, pcw, dreq, wsel, wcnt;
        logic left, done;
        string nm;
        cyc = 0; rf = 0; mw = 0; mdr = 0; pcw = 0;
        dreq = 0; wsel = 0; wcnt = 0;
        left = 1'b0; done = 1'b0;
        bus.opcode = v.op;
        bus.zero = v.zero;
        while (!done && cyc < 40) begin
            cyc++;
            if (bus.mem_req) begin
                bus.mem_ack = (wcnt == (bus.adr_sel ? v.wm : v.wf));
                wcnt = bus.mem_ack ? 0 : wcnt + 1;
            end else begin
                bus.mem_ack = 1'($urandom);
            end
            #1;
            rf   += int'(bus.rf_we);
            mw   += int'(bus.mem_req && bus.mem_we);
            mdr  += int'(bus.mdr_we);
            pcw  += int'(bus.pc_we);
            dreq += int'(bus.mem_req && bus.adr_sel);
            wsel += int'(bus.rf_we && bus.rf_wsel);
            if (!is_fetch()) left = 1'b1;
            @(negedge clk);
            bus.mem_ack = 1'b0;
            #1;
            if ((left && is_fetch()) || !bus.busy) done = 1'b1;
        end
        nm = $sformatf("vec%0d_op%h", idx, v.op);
        chk({nm, "_lat"}, cyc, v.lat);
        chk({nm, "_rf_we"}, rf, v.rf);
        chk({nm, "_mem_we"}, mw, v.mw);
        chk({nm, "_mdr_we"}, mdr, v.mdr);
        chk({nm, "_pc_we"}, pcw, v.pcw);
        chk({nm, "_dreq"}, dreq, v.dreq);
        chk({nm, "_wsel"}, wsel, v.wsel);
    endtask

    task automatic add_vec(input logic [3:0] op, input logic z,
                           input int wf, input int wm, input int lat,
                           input int rf, input int mw, input int mdr,
                           input int pcw, input int dreq, input int wsel);
        vec_t v;
        v.op = op; v.zero = z; v.wf = wf; v.wm = wm; v.lat = lat;
        v.rf = rf; v.mw = mw; v.mdr = mdr; v.pcw = pcw;
        v.dreq = dreq; v.wsel = wsel;
        tbl.push_back(v);
    endtask

    task automatic start_prog();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        exp_t ex;
        cyc_t c;
        logic [3:0] op;

        add_vec(4'h0, 1'b0, 0, 0, 4, 1, 0, 0, 1, 0, 0);
        add_vec(4'h1, 1'b1, 2, 0, 6, 1, 0, 0, 1, 0, 0);
        add_vec(4'h4, 1'b0, 0, 0, 4, 1, 0, 0, 1, 0, 0);
        add_vec(4'h8, 1'b0, 0, 3, 8, 1, 0, 1, 1, 4, 1);
        add_vec(4'h9, 1'b0, 0, 0, 4, 0, 1, 0, 1, 1, 0);
        add_vec(4'h9, 1'b0, 1, 2, 7, 0, 3, 0, 1, 3, 0);
        add_vec(4'hA, 1'b1, 0, 0, 3, 0, 0, 0, 2, 0, 0);
        add_vec(4'hA, 1'b0, 0, 0, 3, 0, 0, 0, 1, 0, 0);
        add_vec(4'hB, 1'b0, 0, 0, 3, 0, 0, 0, 2, 0, 0);
`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        add_vec(4'hC, 1'b0, 0, 0, 2, 0, 0, 0, 1, 0, 0);
`endif
        add_vec(4'h8, 1'b1, 0, 0, 5, 1, 0, 1, 1, 1, 1);

        rst = 1'b1;
        bus.start = 1'b0;
        bus.opcode = '0;
        bus.zero = 1'b0;
        bus.mem_ack = 1'b0;
        #12;
        chk("reset_out", 32'(smp()), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("idle_hold", 32'(smp()), 32'h0);
        end
        bus.mem_ack = 1'b0;
        start_prog();
        #1;
        chk("start_fetch", 32'(is_fetch()), 32'h1);

        foreach (tbl[i]) run_vec(tbl[i], i);

        for (int n = 0; n < 150; n++) begin
            do op = 4'($urandom_range(0, 14));
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            while (!legal(op));
`else
            while (1'b0);
`endif
            push_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
            while (q.size() > 0) begin
                c = q.pop_front();
                bus.opcode = c.op;
                bus.zero = c.zero;
                bus.mem_ack = c.ack;
                bus.start = 1'($urandom);
                #1;
                chk($sformatf("rand_op%h", c.op), 32'(smp()), 32'(c.e));
                @(negedge clk);
            end
        end
        bus.start = 1'b0;

        // LD stalled in the read wait, then reset mid-wait
        bus.opcode = 4'h8;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rd_wait_req", 32'({bus.mem_req, bus.adr_sel, bus.mem_we}),
            32'b110);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst", 32'(smp()), 32'h0);
        @(negedge clk);
        bus.mem_ack = 1'b1;
        #1;
        chk("rst_held", 32'(smp()), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("idle_after_rst", 32'(smp()), 32'h0);
        end
        bus.mem_ack = 1'b0;

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        start_prog();
        bus.opcode = 4'hC;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        @(negedge clk);
        #1;
        ex = '0;
        ex.err = 1'b1;
        chk("trap_halt", 32'(smp()), 32'(ex));
        @(negedge clk);
        #1;
        chk("trap_stay", 32'(smp()), 32'(ex));
        rst = 1'b1;
        #1;
        chk("trap_clr", 32'(smp()), 32'h0);
        @(negedge clk);
        rst = 1'b0;
`endif

        start_prog();
        bus.opcode = 4'hF;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        @(negedge clk);
        #1;
        chk("halt", 32'(smp()), 32'h0);
        for (int i = 0; i < 4; i++) begin
            bus.start = 1'b1;
            bus.mem_ack = 1'($urandom);
            @(negedge clk);
            #1;
            chk("halt_hold", 32'(smp()), 32'h0);
        end
        bus.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_after_halt", 32'(smp()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
